// File: rtl/inst_fifo.sv
// Show-ahead instruction queue between fetch and the dual decode slots.
// Accepts up to two pushes and two pops per cycle; the head pair is presented combinationally.
module inst_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             write_en1,
    input  logic             write_en2,
    input  logic [31:0]      write_inst1,
    input  logic [31:0]      write_inst2,
    input  logic [31:0]      write_pc1,
    input  logic [31:0]      write_pc2,
    input  logic             read_en1,
    input  logic             read_en2,
    output logic [31:0]      read_inst1,
    output logic [31:0]      read_inst2,
    output logic [31:0]      read_pc1,
    output logic [31:0]      read_pc2,
    output logic             read_valid1,
    output logic             read_valid2,
    output logic             empty,
    output logic             almost_full,
    output logic             full,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DepthC   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AlmostC  = (PTR_W+1)'(DEPTH - 2);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W:0]   free;
    logic [PTR_W:0]   pop_req, push_req;
    logic [PTR_W:0]   pop, push;

    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    // Requests and free space are judged on the pre-edge count only.
    always_comb begin
        pop_req  = (PTR_W+1)'(read_en1) + (PTR_W+1)'(read_en1 & read_en2);
        push_req = (PTR_W+1)'(write_en1) + (PTR_W+1)'(write_en1 & write_en2);
        free     = DepthC - count_q;
        pop      = (pop_req > count_q) ? count_q : pop_req;
        push     = (push_req > free) ? free : push_req;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + push - pop;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push != '0) begin
                mem[wr_ptr_q] <= {write_pc1, write_inst1};
            end
            if (push == (PTR_W+1)'(2)) begin
                mem[wr_ptr_p1] <= {write_pc2, write_inst2};
            end
        end
    end

    always_comb begin
        read_valid1 = (count_q != '0);
        read_valid2 = (count_q >= (PTR_W+1)'(2));
        empty       = (count_q == '0);
        almost_full = (count_q >= AlmostC);
        full        = (count_q == DepthC);
        count       = count_q;
    end

    // Invalid slots read as zero so the decoder sees a NOP.
    always_comb begin
        read_inst1 = '0;
        read_pc1   = '0;
        read_inst2 = '0;
        read_pc2   = '0;
        if (read_valid1) begin
            read_inst1 = mem[rd_ptr_q][31:0];
            read_pc1   = mem[rd_ptr_q][63:32];
        end
        if (read_valid2) begin
            read_inst2 = mem[rd_ptr_p1][31:0];
            read_pc2   = mem[rd_ptr_p1][63:32];
        end
    end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: vector table for single-cycle behaviour plus
// hand-written fill, wrap, flush and asynchronous reset sequences.
module tb_inst_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, write_en1, write_en2, read_en1, read_en2;
    logic [31:0] write_inst1, write_inst2, write_pc1, write_pc2;
    logic [31:0] read_inst1, read_inst2, read_pc1, read_pc2;
    logic        read_valid1, read_valid2, empty, almost_full, full;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_inst1(write_inst1), .write_inst2(write_inst2),
        .write_pc1(write_pc1), .write_pc2(write_pc2),
        .read_en1(read_en1), .read_en2(read_en2),
        .read_inst1(read_inst1), .read_inst2(read_inst2),
        .read_pc1(read_pc1), .read_pc2(read_pc2),
        .read_valid1(read_valid1), .read_valid2(read_valid2),
        .empty(empty), .almost_full(almost_full), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            assert (count <= 5'(DEPTH));
        end
    end

    typedef struct {
        logic        fl, we1, we2, re1, re2;
        logic [31:0] wi1, wp1, wi2, wp2;
        int          cnt;
        logic [31:0] ri1, rp1, ri2, rp2;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic fl, logic we1, logic we2, logic [31:0] wi1,
                                logic [31:0] wp1, logic [31:0] wi2, logic [31:0] wp2,
                                logic re1, logic re2, int cnt, logic [31:0] ri1,
                                logic [31:0] rp1, logic [31:0] ri2, logic [31:0] rp2);
        vec_t v;
        v.fl = fl; v.we1 = we1; v.we2 = we2; v.re1 = re1; v.re2 = re2;
        v.wi1 = wi1; v.wp1 = wp1; v.wi2 = wi2; v.wp2 = wp2;
        v.cnt = cnt; v.ri1 = ri1; v.rp1 = rp1; v.ri2 = ri2; v.rp2 = rp2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input int cnt, input logic [31:0] i1,
                               input logic [31:0] p1, input logic [31:0] i2,
                               input logic [31:0] p2);
        chk({nm, ".count"}, 32'(count), 32'(cnt));
        chk({nm, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({nm, ".valid1"}, 32'(read_valid1), 32'(cnt >= 1));
        chk({nm, ".valid2"}, 32'(read_valid2), 32'(cnt >= 2));
        chk({nm, ".almost_full"}, 32'(almost_full), 32'(cnt >= DEPTH - 2));
        chk({nm, ".full"}, 32'(full), 32'(cnt == DEPTH));
        chk({nm, ".inst1"}, read_inst1, i1);
        chk({nm, ".pc1"}, read_pc1, p1);
        chk({nm, ".inst2"}, read_inst2, i2);
        chk({nm, ".pc2"}, read_pc2, p2);
    endtask

    task automatic drive(input logic fl, input logic we1, input logic we2,
                         input logic [31:0] wi1, input logic [31:0] wp1,
                         input logic [31:0] wi2, input logic [31:0] wp2,
                         input logic re1, input logic re2);
        @(negedge clk);
        flush = fl; write_en1 = we1; write_en2 = we2;
        write_inst1 = wi1; write_pc1 = wp1; write_inst2 = wi2; write_pc2 = wp2;
        read_en1 = re1; read_en2 = re2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] fi(int k);
        return 32'hA000_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] fp(int k);
        return 32'h0001_0000 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] wi(int n);
        return 32'h2000_0000 | 32'(n);
    endfunction

    function automatic logic [31:0] wp(int n);
        return 32'h8000_0000 + 32'(4 * n);
    endfunction

    initial begin
        resetn = 1'b0;
        flush = 0; write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
        write_inst1 = '0; write_inst2 = '0; write_pc1 = '0; write_pc2 = '0;

        vecs[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(0, 1, 1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004, 0, 0,
                     2, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004);
        vecs[2] = mk(0, 1, 0, 32'h3C03A000, 32'hBFC00008, 32'h0BAD0BAD, 32'h0BAD0BAD, 1, 1,
                     1, 32'h3C03A000, 32'hBFC00008, 0, 0);
        vecs[3] = mk(0, 0, 1, 32'h0BAD0001, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0002, 0, 0,
                     1, 32'h3C03A000, 32'hBFC00008, 0, 0);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3C03A000, 32'hBFC00008, 0, 0);
        vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(0, 1, 1, 32'h11110000, 32'h00000100, 32'h22220000, 32'h00000104, 1, 0,
                     2, 32'h11110000, 32'h00000100, 32'h22220000, 32'h00000104);
        vecs[8] = mk(0, 1, 0, 32'h33330000, 32'h00000108, 0, 0, 1, 0,
                     2, 32'h22220000, 32'h00000104, 32'h33330000, 32'h00000108);
        vecs[9] = mk(1, 1, 0, 32'h44440000, 32'h0000010C, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fl, vecs[i].we1, vecs[i].we2, vecs[i].wi1, vecs[i].wp1,
                  vecs[i].wi2, vecs[i].wp2, vecs[i].re1, vecs[i].re2);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ri1, vecs[i].rp1,
                        vecs[i].ri2, vecs[i].rp2);
        end

        // Fill to full, overflow attempt, then drain in pairs.
        for (int j = 0; j < 7; j++) begin
            drive(0, 1, 1, fi(2 * j), fp(2 * j), fi(2 * j + 1), fp(2 * j + 1), 0, 0);
            if (j == 5) check_state("fill12", 12, fi(0), fp(0), fi(1), fp(1));
        end
        check_state("fill14", 14, fi(0), fp(0), fi(1), fp(1));
        drive(0, 1, 1, fi(14), fp(14), fi(15), fp(15), 0, 0);
        check_state("fill16", 16, fi(0), fp(0), fi(1), fp(1));
        drive(0, 1, 1, 32'hDEAD0001, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0002, 0, 0);
        for (int j = 0; j < 8; j++) begin
            check_state($sformatf("drain%0d", j), 16 - 2 * j, fi(2 * j), fp(2 * j),
                        fi(2 * j + 1), fp(2 * j + 1));
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        end
        check_state("drained", 0, 0, 0, 0, 0);

        // Count 15 plus a pair: only slot 1 lands.
        for (int j = 0; j < 7; j++) begin
            drive(0, 1, 1, fi(2 * j), fp(2 * j), fi(2 * j + 1), fp(2 * j + 1), 0, 0);
        end
        drive(0, 1, 0, fi(14), fp(14), 0, 0, 0, 0);
        check_state("fill15", 15, fi(0), fp(0), fi(1), fp(1));
        drive(0, 1, 1, fi(15), fp(15), 32'hDEAD0003, 32'hDEAD0003, 0, 0);
        for (int k = 0; k < 16; k++) begin
            check_state($sformatf("pop%0d", k), 16 - k, fi(k), fp(k),
                        (k < 15) ? fi(k + 1) : 32'h0, (k < 15) ? fp(k + 1) : 32'h0);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        check_state("popdone", 0, 0, 0, 0, 0);

        // Wrap: offset pointers by one, then stream pairs through indices 15/0.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'hDEAD0004, 32'hDEAD0004, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_state("offset", 0, 0, 0, 0, 0);
        drive(0, 1, 1, wi(0), wp(0), wi(1), wp(1), 0, 0);
        for (int i = 0; i < 20; i++) begin
            check_state($sformatf("wrap%0d", i), 2, wi(2 * i), wp(2 * i),
                        wi(2 * i + 1), wp(2 * i + 1));
            if (i < 19) drive(0, 1, 1, wi(2 * i + 2), wp(2 * i + 2), wi(2 * i + 3),
                              wp(2 * i + 3), 1, 1);
            else drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        end
        check_state("wrapdone", 0, 0, 0, 0, 0);

        // Flush at count 5 with a concurrent push and pop.
        drive(0, 1, 1, fi(0), fp(0), fi(1), fp(1), 0, 0);
        drive(0, 1, 1, fi(2), fp(2), fi(3), fp(3), 0, 0);
        drive(0, 1, 0, fi(4), fp(4), 0, 0, 0, 0);
        check_state("pre_flush", 5, fi(0), fp(0), fi(1), fp(1));
        drive(1, 1, 0, 32'h55550000, 32'h00000200, 0, 0, 1, 0);
        check_state("flush", 0, 0, 0, 0, 0);
        idle();
        check_state("post_flush", 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h66660000, 32'h00000300, 0, 0, 0, 0);
        check_state("after_flush_push", 1, 32'h66660000, 32'h00000300, 0, 0);

        // Asynchronous reset mid-cycle at count 7.
        drive(0, 1, 1, fi(0), fp(0), fi(1), fp(1), 0, 0);
        drive(0, 1, 1, fi(2), fp(2), fi(3), fp(3), 0, 0);
        drive(0, 1, 1, fi(4), fp(4), fi(5), fp(5), 0, 0);
        check_state("pre_reset", 7, 32'h66660000, 32'h00000300, fi(0), fp(0));
        @(negedge clk);
        write_en1 = 0; write_en2 = 0;
        #2;
        resetn = 1'b0;
        #1;
        check_state("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        check_state("post_reset", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
